// File: rtl/pixel_readout_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_readout_ctrl
//
// Sequencer for a four-pixel sensor: erase -> expose -> convert (ramp counter
// driven onto all pixel buses) -> sequential readout of each pixel with a
// valid/ready handshake towards the downstream consumer.
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               synchronous active-high reset
//   start               frame request, only looked at while idle
//   erase/expose        common pulses to all four pixels
//   convert             ramp active; counter value is driven on the buses
//   read[3:0]           one-hot pixel read select (bit i -> pixel i+1)
//   pixData1..4         bidirectional 8-bit pixel buses
//   pix_out/pix_idx     captured pixel value and its index
//   pix_valid           pix_out/pix_idx valid, held until pix_ready
//   pix_ready           downstream accepts the pixel
//   busy                high whenever the controller is not idle
//
// Every output (including the bus drive enable and bus value) comes straight
// from a flop; the flops are loaded from the next-state decode so that the
// outputs line up with the state they belong to.
// ---------------------------------------------------------------------------
module pixel_readout_ctrl #(
  parameter int C_ERASE   = 5,
  parameter int C_EXPOSE  = 255,
  parameter int C_CONVERT = 256,
  parameter int C_READ    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       erase,
  output logic       expose,
  output logic       convert,
  output logic [3:0] read,
  inout  wire  [7:0] pixData1,
  inout  wire  [7:0] pixData2,
  inout  wire  [7:0] pixData3,
  inout  wire  [7:0] pixData4,
  output logic [7:0] pix_out,
  output logic [1:0] pix_idx,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_EXPOSE,
    S_CONVERT,
    S_TURN,
    S_READ,
    S_HOLD
  } state_t;

  // Terminal counts; 9 bits so a 256-cycle convert phase fits.
  localparam logic [8:0] ERASE_LAST   = 9'(C_ERASE - 1);
  localparam logic [8:0] EXPOSE_LAST  = 9'(C_EXPOSE - 1);
  localparam logic [8:0] CONVERT_LAST = 9'(C_CONVERT - 1);
  localparam logic [8:0] READ_LAST    = 9'(C_READ - 1);

  state_t      state_reg, state_next;
  logic [8:0]  cnt_reg, cnt_next;
  logic [1:0]  idx_reg, idx_next;

  logic        erase_reg, erase_next;
  logic        expose_reg, expose_next;
  logic        convert_reg, convert_next;
  logic [3:0]  read_reg, read_next;
  logic        drive_reg, drive_next;
  logic [7:0]  ramp_reg, ramp_next;
  logic [7:0]  pix_out_reg, pix_out_next;
  logic [1:0]  pix_idx_reg, pix_idx_next;
  logic        pix_valid_reg, pix_valid_next;
  logic        busy_reg, busy_next;

  logic [7:0]  bus_in [4];
  logic [7:0]  sel_data;

  assign bus_in[0] = pixData1;
  assign bus_in[1] = pixData2;
  assign bus_in[2] = pixData3;
  assign bus_in[3] = pixData4;
  assign sel_data  = bus_in[idx_reg];

  // The buses are only ever driven during CONVERT, so the controller can
  // never fight a pixel that has been selected by read.
  assign pixData1 = drive_reg ? ramp_reg : 8'hzz;
  assign pixData2 = drive_reg ? ramp_reg : 8'hzz;
  assign pixData3 = drive_reg ? ramp_reg : 8'hzz;
  assign pixData4 = drive_reg ? ramp_reg : 8'hzz;

  // Next-state and next-output decode.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 9'd1;
    idx_next       = idx_reg;
    pix_out_next   = pix_out_reg;
    pix_idx_next   = pix_idx_reg;
    pix_valid_next = pix_valid_reg;

    unique case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (start) state_next = S_ERASE;
      end
      S_ERASE: begin
        if (cnt_reg == ERASE_LAST) begin
          state_next = S_EXPOSE;
          cnt_next   = '0;
        end
      end
      S_EXPOSE: begin
        if (cnt_reg == EXPOSE_LAST) begin
          state_next = S_CONVERT;
          cnt_next   = '0;
        end
      end
      S_CONVERT: begin
        if (cnt_reg == CONVERT_LAST) begin
          state_next = S_TURN;
          cnt_next   = '0;
          idx_next   = '0;
        end
      end
      S_TURN: begin
        state_next = S_READ;
        cnt_next   = '0;
      end
      S_READ: begin
        if (cnt_reg == READ_LAST) begin
          // Pixel is still driving the bus during this cycle; capture now.
          state_next     = S_HOLD;
          cnt_next       = '0;
          pix_out_next   = sel_data;
          pix_idx_next   = idx_reg;
          pix_valid_next = 1'b1;
        end
      end
      S_HOLD: begin
        cnt_next = '0;
        if (pix_valid_reg && pix_ready) begin
          pix_valid_next = 1'b0;
          if (idx_reg == 2'd3) begin
            state_next = S_IDLE;
          end else begin
            idx_next   = idx_reg + 2'd1;
            state_next = S_TURN;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    erase_next   = (state_next == S_ERASE);
    expose_next  = (state_next == S_EXPOSE);
    convert_next = (state_next == S_CONVERT);
    drive_next   = (state_next == S_CONVERT);
    // cnt_next restarts at 0 on entry to CONVERT, so it doubles as the ramp.
    ramp_next    = (state_next == S_CONVERT) ? cnt_next[7:0] : 8'd0;
    read_next    = (state_next == S_READ) ? (4'b0001 << idx_next) : 4'b0000;
    busy_next    = (state_next != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      erase_reg     <= 1'b0;
      expose_reg    <= 1'b0;
      convert_reg   <= 1'b0;
      read_reg      <= '0;
      drive_reg     <= 1'b0;
      ramp_reg      <= '0;
      pix_out_reg   <= '0;
      pix_idx_reg   <= '0;
      pix_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      erase_reg     <= erase_next;
      expose_reg    <= expose_next;
      convert_reg   <= convert_next;
      read_reg      <= read_next;
      drive_reg     <= drive_next;
      ramp_reg      <= ramp_next;
      pix_out_reg   <= pix_out_next;
      pix_idx_reg   <= pix_idx_next;
      pix_valid_reg <= pix_valid_next;
      busy_reg      <= busy_next;
    end
  end

  assign erase     = erase_reg;
  assign expose    = expose_reg;
  assign convert   = convert_reg;
  assign read      = read_reg;
  assign pix_out   = pix_out_reg;
  assign pix_idx   = pix_idx_reg;
  assign pix_valid = pix_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pixel_readout_ctrl
//
// Bench for pixel_readout_ctrl with short phase lengths. Four pixel models
// latch the ramp at 3/7/11/15 and drive it back when selected by read.
// Expected pixels are queued when a frame is started and checked as the
// controller hands them over; per-cycle invariants run alongside.
// ---------------------------------------------------------------------------
module tb_pixel_readout_ctrl;
  localparam int CE = 2;
  localparam int CX = 4;
  localparam int CC = 16;
  localparam int CR = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pix_ready = 1'b1;
  wire        erase, expose, convert, pix_valid, busy;
  wire  [3:0] read;
  wire  [7:0] pd1, pd2, pd3, pd4, pix_out;
  wire  [1:0] pix_idx;

  always #5 clk = ~clk;

  pixel_readout_ctrl #(
    .C_ERASE(CE), .C_EXPOSE(CX), .C_CONVERT(CC), .C_READ(CR)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .erase(erase), .expose(expose), .convert(convert), .read(read),
    .pixData1(pd1), .pixData2(pd2), .pixData3(pd3), .pixData4(pd4),
    .pix_out(pix_out), .pix_idx(pix_idx), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy)
  );

  // Pixel models.
  logic [7:0] lat0 = 8'd0, lat1 = 8'd0, lat2 = 8'd0, lat3 = 8'd0;
  always @(posedge clk) begin
    if (convert) begin
      if (pd1 == 8'd3)  lat0 <= pd1;
      if (pd2 == 8'd7)  lat1 <= pd2;
      if (pd3 == 8'd11) lat2 <= pd3;
      if (pd4 == 8'd15) lat3 <= pd4;
    end
  end
  assign pd1 = read[0] ? lat0 : 8'hzz;
  assign pd2 = read[1] ? lat1 : 8'hzz;
  assign pd3 = read[2] ? lat2 : 8'hzz;
  assign pd4 = read[3] ? lat3 : 8'hzz;

  int n_vec = 0;
  int n_mis = 0;
  int exp_q[$];
  int c_busy = 0, c_erase = 0, c_expose = 0, c_convert = 0, c_valid = 0, c_xfer = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_frame();
    exp_q.push_back(0 * 256 + 3);
    exp_q.push_back(1 * 256 + 7);
    exp_q.push_back(2 * 256 + 11);
    exp_q.push_back(3 * 256 + 15);
  endtask

  // Per-cycle observer: invariants, ramp model, hold stability, scoreboard.
  task automatic monitor();
    int         exp_conv = 0;
    int         e;
    logic       prev_conv = 1'b0, prev_valid = 1'b0, prev_xfer = 1'b0;
    logic [7:0] prev_out = 8'd0;
    logic [1:0] prev_idx = 2'd0;
    forever begin
      @(negedge clk);
      chk("read_onehot0", int'($onehot0(read)), 1);
      chk("ctl_exclusive",
          int'(int'(erase) + int'(expose) + int'(convert) + int'(read != 4'd0) <= 1), 1);
      chk("drive_while_read", int'(read != 4'd0 && convert), 0);
      if (convert) begin
        exp_conv = prev_conv ? exp_conv + 1 : 0;
        chk("ramp_bus1", pd1, exp_conv);
        chk("ramp_bus2", pd2, exp_conv);
        chk("ramp_bus3", pd3, exp_conv);
        chk("ramp_bus4", pd4, exp_conv);
      end
      if (pix_valid && prev_valid && !prev_xfer) begin
        chk("hold_out", pix_out, prev_out);
        chk("hold_idx", pix_idx, prev_idx);
        chk("hold_read", read, 0);
      end
      if (busy)      c_busy++;
      if (erase)     c_erase++;
      if (expose)    c_expose++;
      if (convert)   c_convert++;
      if (pix_valid) c_valid++;
      if (pix_valid && pix_ready) begin
        c_xfer++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pix", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("pix_idx", pix_idx, e / 256);
          chk("pix_out", pix_out, e % 256);
          $display("xfer idx=%0d val=%0d", pix_idx, pix_out);
        end
      end
      prev_conv  = convert;
      prev_valid = pix_valid;
      prev_xfer  = pix_valid && pix_ready;
      prev_out   = pix_out;
      prev_idx   = pix_idx;
    end
  endtask

  task automatic wait_busy_low(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", busy, 0);
  endtask

  // One frame; stall>0 withholds pix_ready for that many cycles on pixel 1.
  task automatic run_frame(input int stall);
    int b0 = c_busy, e0 = c_erase, x0 = c_expose, v0 = c_convert;
    int h0 = c_valid, t0 = c_xfer;
    int n;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_latency", erase, 1);
    chk("busy_rise", busy, 1);
    // Stray start request while busy must be ignored.
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (stall > 0) begin
      n = 0;
      while (read != 4'b0010 && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("wait_read1", read, 2);
      pix_ready = 1'b0;
      n = 0;
      while (!pix_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      repeat (stall) begin
        chk("bp_valid", pix_valid, 1);
        chk("bp_out", pix_out, 7);
        chk("bp_read", read, 0);
        @(negedge clk);
      end
      @(posedge clk); #1 pix_ready = 1'b1;
    end
    wait_busy_low(500);
    chk("erase_len", c_erase - e0, CE);
    chk("expose_len", c_expose - x0, CX);
    chk("convert_len", c_convert - v0, CC);
    chk("frame_len", (c_busy - b0) - (c_valid - h0), CE + CX + CC + 4 * (CR + 1));
    chk("hold_len", c_valid - h0, (stall > 0) ? stall + 5 : 4);
    chk("xfer_count", c_xfer - t0, 4);
    repeat (5) @(negedge clk);
    chk("idle_after", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    int b0, e0, t0, h0;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_erase", erase, 0);
    chk("rst_expose", expose, 0);
    chk("rst_convert", convert, 0);
    chk("rst_read", read, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_out", pix_out, 0);
    chk("rst_idx", pix_idx, 0);
    chk("rst_busy", busy, 0);

    run_frame(0);
    run_frame(10);

    // Reset in the middle of CONVERT.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(convert && pd1 == 8'd8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_conv_count", pd1, 8);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_erase", erase, 0);
    chk("abort_expose", expose, 0);
    chk("abort_convert", convert, 0);
    chk("abort_read", read, 0);
    chk("abort_valid", pix_valid, 0);
    chk("abort_out", pix_out, 0);
    chk("abort_idx", pix_idx, 0);
    chk("abort_busy", busy, 0);
    reset = 1'b0;
    h0 = c_valid;
    repeat (50) @(negedge clk);
    chk("abort_no_valid", c_valid - h0, 0);
    chk("abort_idle", busy, 0);

    run_frame(0);

    // start held high: two back-to-back frames.
    push_frame();
    push_frame();
    b0 = c_busy; e0 = c_erase; t0 = c_xfer;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_busy1", busy, 1);
    wait_busy_low(500);
    @(negedge clk);
    chk("b2b_reenter", erase, 1);
    repeat (4) @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    wait_busy_low(500);
    chk("b2b_erase_total", c_erase - e0, 2 * CE);
    chk("b2b_busy_total", c_busy - b0, 2 * (CE + CX + CC + 4 * (CR + 2)));
    chk("b2b_xfers", c_xfer - t0, 8);
    repeat (5) @(negedge clk);
    chk("b2b_idle_after", busy, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/pixel_readout_ctrl.md
PIXEL_READOUT_CTRL -- requirements
Module: pixel_readout_ctrl

Interface
REQ-001 Parameter C_ERASE, default 5, erase pulse length in clk cycles (1..255).
REQ-002 Parameter C_EXPOSE, default 255, expose pulse length in clk cycles (1..255).
REQ-003 Parameter C_CONVERT, default 256, ramp/counter length in clk cycles (1..256).
REQ-004 Parameter C_READ, default 5, read pulse length per pixel in clk cycles (1..255).
REQ-005 Clocking shall be one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  level-sampled frame request, honoured only in IDLE.
REQ-009 erase  output  1  common erase to all four pixels.
REQ-010 expose  output  1  common expose to all four pixels.
REQ-011 convert  output  1  ramp active; counter driven on pixel buses.
REQ-012 read  output  4  one-hot pixel read select; bit i selects pixel i+1.
REQ-013 pixData1..pixData4  inout  8 each  pixel data buses.
REQ-014 pix_out  output  8  captured pixel value.
REQ-015 pix_idx  output  2  index (0..3) of pixel in pix_out.
REQ-016 pix_valid  output  1  pix_out/pix_idx valid.
REQ-017 pix_ready  input  1  downstream accepts the pixel.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ERASE, EXPOSE, CONVERT, TURN, READ, HOLD; exactly one active.
REQ-020 IDLE: start=1 at edge N -> ERASE from cycle N+1; otherwise remain in IDLE; start is ignored in all other states.
REQ-021 ERASE: erase=1 for exactly C_ERASE cycles, then EXPOSE.
REQ-022 EXPOSE: expose=1 for exactly C_EXPOSE cycles, then CONVERT.
REQ-023 CONVERT: convert=1 for exactly C_CONVERT cycles; 8-bit counter=0 on the first cycle, +1 per cycle, no wrap within the phase.
REQ-024 CONVERT: the counter value shall be driven on all four pixData buses; the buses shall be high-Z in every other state.
REQ-025 After CONVERT: pixel index i=0, go to TURN.
REQ-026 TURN: one cycle, all outputs except busy low, buses high-Z (bus turnaround); then READ.
REQ-027 READ: read[i]=1, other read bits 0, for exactly C_READ cycles.
REQ-028 On the last READ cycle: pix_out <= pixData(i+1), pix_idx <= i; go to HOLD with pix_valid=1 and read=0 on the next cycle.
REQ-029 HOLD: pix_valid, pix_out and pix_idx shall stay stable until pix_valid&pix_ready is sampled high at an edge.
REQ-030 On transfer: pix_valid=0 on the next cycle; if i<3, i<=i+1 and go to TURN; if i=3, go to IDLE.
REQ-031 pix_ready is a don't-care when pix_valid=0; pix_ready held high gives 1-cycle HOLD.
REQ-032 The controller shall never drive any pixData bus while any read bit is 1.
REQ-033 erase, expose, convert and read shall be mutually exclusive in every cycle.
REQ-034 Frame length with pix_ready=1: C_ERASE+C_EXPOSE+C_CONVERT+4*(C_READ+2) cycles from first erase cycle to return to IDLE.
REQ-035 All outputs shall be registered; no combinational path from start or pix_ready to any output.

Reset
REQ-036 reset=1 at an edge in any state shall give IDLE on the next cycle: erase=expose=convert=0, read=0000, pix_valid=0, pix_out=0, pix_idx=0, busy=0, counters 0, all buses high-Z.
REQ-037 reset has priority over start and pix_ready; an aborted frame produces no further pix_valid.

Verification (C_ERASE=2, C_EXPOSE=4, C_CONVERT=16, C_READ=2; pixel models latch the bus when convert count equals 3, 7, 11, 15)
REQ-038 Single frame, pix_ready=1: start pulse -> erase 2 cycles, expose 4, convert 16 with bus 0..15; pix_out 3,7,11,15 with pix_idx 0..3; busy low after 16 read-phase cycles.
REQ-039 Backpressure: pix_ready=0 for 10 cycles on pixel 1 -> pix_valid held 10+ cycles, pix_out=7 stable, read stays 0000, then resume normally.
REQ-040 Reset in mid-CONVERT (count=8) -> next cycle all outputs 0, buses Z, no pix_valid; a later start runs a full, correct frame.
REQ-041 start held high continuously -> back-to-back frames, each re-entering ERASE one cycle after IDLE; start pulses while busy are ignored.
REQ-042 Every cycle, assert one-hot/zero read, control exclusivity, and no controller drive while read is nonzero (X/contention check on pixData).
